// File: rtl/ascensor_pkg.sv
// ascensor_pkg: shared state encoding and call-search helpers for the elevator controller.
package ascensor_pkg;

    typedef enum logic [2:0] {INIT, IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

    function automatic logic any_above(input logic [15:0] p, input logic [3:0] f);
        return |(p >> (5'(f) + 5'd1));
    endfunction

    function automatic logic any_below(input logic [15:0] p, input logic [3:0] f);
        return |(p & ((16'd1 << f) - 16'd1));
    endfunction

endpackage

// File: rtl/elev_door_timer.sv
// elev_door_timer: door-open down-counter; loaded on door entry, reloaded while held.
module elev_door_timer #(
    parameter int CYCLES = 8,
    localparam int CW = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic reload,
    output logic done
);

    logic [CW-1:0] cnt;

    // Counts CYCLES-1 down to 0, so the door spends exactly CYCLES cycles open.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load || reload) cnt <= CW'(CYCLES - 1);
        else if (cnt != '0) cnt <= cnt - 1'b1;

    assign done = (cnt == '0) && !reload;

endmodule

// File: rtl/elev_call_ctrl.sv
// elev_call_ctrl: SCAN elevator controller exciting the UP/DOWN motor JK flip-flops.
// Define ELEV_DOOR_HOLD_EN to add the door_hold input that keeps the door open.
module elev_call_ctrl
    import ascensor_pkg::*;
#(
    parameter int N_FLOORS = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FLOOR_W = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                floor_tick,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                door_hold,
`endif
    output logic                j_up,
    output logic                k_up,
    output logic                j_dn,
    output logic                k_dn,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up
);

    state_t state, nxt, idle_nxt;
    logic [FLOOR_W-1:0] floor_n;
    logic [N_FLOORS-1:0] cur_bit, eff, pending_n;
    logic above, below, door_done, hold, load;
    logic ju_n, ku_n, jd_n, kd_n, dir_n;

    // Calls for the floor the door is open at are dropped, so they never latch.
    assign cur_bit = N_FLOORS'(1) << cur_floor;
    assign eff = (pending | call_req) & ~((state == DOOR) ? cur_bit : '0);
    assign above = any_above(16'(eff), 4'(cur_floor));
    assign below = any_below(16'(eff), 4'(cur_floor));
    assign idle_nxt = eff[cur_floor] ? DOOR :
                      (above && (dir_up || !below)) ? MOVE_UP :
                      below ? MOVE_DN : IDLE;

    always_comb begin
        nxt = state;
        floor_n = cur_floor;
        case (state)
            INIT:    nxt = IDLE;
            IDLE:    nxt = idle_nxt;
            MOVE_UP:
                if (cur_floor == FLOOR_W'(N_FLOORS - 1)) nxt = IDLE;
                else if (floor_tick) begin
                    floor_n = cur_floor + 1'b1;
                    nxt = eff[floor_n] ? DOOR : MOVE_UP;
                end
            MOVE_DN:
                if (cur_floor == '0) nxt = IDLE;
                else if (floor_tick) begin
                    floor_n = cur_floor - 1'b1;
                    nxt = eff[floor_n] ? DOOR : MOVE_DN;
                end
            DOOR:    nxt = door_done ? idle_nxt : DOOR;
            default: nxt = INIT;
        endcase
    end

    assign pending_n = eff & ~((state == DOOR || nxt == DOOR) ? (N_FLOORS'(1) << floor_n) : '0);
    assign ju_n = (nxt == MOVE_UP) && (state != MOVE_UP);
    assign jd_n = (nxt == MOVE_DN) && (state != MOVE_DN);
    assign ku_n = (state == INIT) || ((state == MOVE_UP) && (nxt != MOVE_UP));
    assign kd_n = (state == INIT) || ((state == MOVE_DN) && (nxt != MOVE_DN));
    assign dir_n = ju_n ? 1'b1 : jd_n ? 1'b0 : dir_up;
    assign load = (nxt == DOOR) && (state != DOOR);
    assign door_open = (state == DOOR);

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = (state == DOOR) && door_hold;
`else
    assign hold = 1'b0;
`endif

    elev_door_timer #(.CYCLES(DOOR_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .reload (hold),
        .done   (door_done)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= INIT;
            cur_floor <= '0;
            pending   <= '0;
            dir_up    <= 1'b1;
            j_up      <= 1'b0;
            k_up      <= 1'b0;
            j_dn      <= 1'b0;
            k_dn      <= 1'b0;
        end else begin
            state     <= nxt;
            cur_floor <= floor_n;
            pending   <= pending_n;
            dir_up    <= dir_n;
            j_up      <= ju_n;
            k_up      <= ku_n;
            j_dn      <= jd_n;
            k_dn      <= kd_n;
        end

endmodule

// File: tb/tb_elev_call_ctrl.sv
// tb_elev_call_ctrl: directed and random stimulus against a behavioural elevator model.
module tb_elev_call_ctrl;

    localparam int N = 4;
    localparam int DC = 8;
    localparam int M_INIT = 0, M_IDLE = 1, M_UP = 2, M_DN = 3, M_DOOR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] call_req = '0;
    logic floor_tick = 1'b0;
    logic door_hold = 1'b0;
    logic j_up, k_up, j_dn, k_dn, door_open, dir_up;
    logic [1:0] cur_floor;
    logic [N-1:0] pending;

    int n_chk = 0;
    int n_fail = 0;

    int m_mode = M_INIT, m_floor = 0, m_left = 0;
    bit m_dir = 1'b1;
    bit [N-1:0] m_pend = '0;
    bit m_ju = 0, m_ku = 0, m_jd = 0, m_kd = 0;

    always #5 clk = ~clk;

    elev_call_ctrl #(.N_FLOORS(N), .DOOR_CYCLES(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .call_req   (call_req),
        .floor_tick (floor_tick),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold  (door_hold),
`endif
        .j_up       (j_up),
        .k_up       (k_up),
        .j_dn       (j_dn),
        .k_dn       (k_dn),
        .cur_floor  (cur_floor),
        .door_open  (door_open),
        .pending    (pending),
        .dir_up     (dir_up)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // SCAN decision from the list of outstanding calls.
    task automatic m_choose(input bit [N-1:0] c);
        bit up, dn;
        up = 0;
        dn = 0;
        for (int i = 0; i < N; i++) begin
            if (c[i] && i > m_floor) up = 1;
            if (c[i] && i < m_floor) dn = 1;
        end
        if (c[m_floor]) begin m_mode = M_DOOR; m_left = DC; end
        else if (up && (m_dir || !dn)) begin m_mode = M_UP; m_ju = 1; m_dir = 1; end
        else if (dn) begin m_mode = M_DN; m_jd = 1; m_dir = 0; end
        else m_mode = M_IDLE;
    endtask

    initial forever begin
        bit [N-1:0] c;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = M_INIT; m_floor = 0; m_dir = 1; m_pend = '0; m_left = 0;
            m_ju = 0; m_ku = 0; m_jd = 0; m_kd = 0;
        end else begin
            c = m_pend | call_req;
            if (m_mode == M_DOOR) c[m_floor] = 0;
            m_ju = 0; m_ku = 0; m_jd = 0; m_kd = 0;
            case (m_mode)
                M_INIT: begin m_ku = 1; m_kd = 1; m_mode = M_IDLE; end
                M_IDLE: m_choose(c);
                M_UP:
                    if (m_floor == N - 1) begin m_ku = 1; m_mode = M_IDLE; end
                    else if (floor_tick) begin
                        m_floor++;
                        if (c[m_floor]) begin m_ku = 1; m_mode = M_DOOR; m_left = DC; end
                    end
                M_DN:
                    if (m_floor == 0) begin m_kd = 1; m_mode = M_IDLE; end
                    else if (floor_tick) begin
                        m_floor--;
                        if (c[m_floor]) begin m_kd = 1; m_mode = M_DOOR; m_left = DC; end
                    end
                default:
                    if (door_hold) m_left = DC;
                    else begin
                        m_left--;
                        if (m_left == 0) m_choose(c);
                    end
            endcase
            m_pend = c;
            if (m_mode == M_DOOR) m_pend[m_floor] = 0;
        end
    end

    always @(negedge clk) begin
        chk("j_up", j_up, m_ju);
        chk("k_up", k_up, m_ku);
        chk("j_dn", j_dn, m_jd);
        chk("k_dn", k_dn, m_kd);
        chk("cur_floor", cur_floor, m_floor);
        chk("door_open", door_open, m_mode == M_DOOR);
        chk("pending", pending, m_pend);
        chk("dir_up", dir_up, m_dir);
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        floor_tick = 1'b1;
        nxt();
        floor_tick = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) nxt();
        chk("rst_k_up", k_up, 0);
        chk("rst_door", door_open, 0);
        chk("rst_dir", dir_up, 1);
        rst_n = 1'b1;
        nxt();
        chk("init_k_up", k_up, 1);
        chk("init_k_dn", k_dn, 1);
        nxt();
        chk("idle_k_up", k_up, 0);
        call_req = 4'b0100;
        nxt();
        call_req = '0;
        chk("go_j_up", j_up, 1);
        tick();
        chk("floor1", cur_floor, 1);
        tick();
        chk("floor2", cur_floor, 2);
        chk("arrive_k_up", k_up, 1);
        chk("door2", door_open, 1);
        chk("pend_clr", pending, 0);
        call_req = 4'b1001;
        nxt();
        call_req = '0;
        repeat (6) nxt();
        chk("door2_last", door_open, 1);
        chk("pend_1001", pending, 4'b1001);
        nxt();
        chk("door2_closed", door_open, 0);
        chk("continue_j_up", j_up, 1);
        tick();
        chk("floor3", cur_floor, 3);
        chk("door3", door_open, 1);
        repeat (7) nxt();
        chk("door3_last", door_open, 1);
        nxt();
        chk("reverse_j_dn", j_dn, 1);
        chk("reverse_dir", dir_up, 0);
        tick(); nxt();
        tick(); nxt();
        tick();
        chk("floor0", cur_floor, 0);
        chk("arrive_k_dn", k_dn, 1);
        chk("door0", door_open, 1);
        call_req = 4'b0001;
        nxt();
        call_req = '0;
        chk("door_call_dropped", pending, 0);
        repeat (6) nxt();
        chk("door0_last", door_open, 1);
        nxt();
        chk("door0_closed", door_open, 0);
        call_req = 4'b1000;
        nxt();
        call_req = '0;
        chk("go2_j_up", j_up, 1);
        tick();
        chk("mid_floor1", cur_floor, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_floor", cur_floor, 0);
        chk("abort_pend", pending, 0);
        chk("abort_k_up", k_up, 0);
        chk("abort_dir", dir_up, 1);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("reinit_k_up", k_up, 1);
        chk("reinit_k_dn", k_dn, 1);
        nxt();
`ifdef ELEV_DOOR_HOLD_EN
        call_req = 4'b0010;
        nxt();
        call_req = '0;
        tick();
        chk("hold_door", door_open, 1);
        cnt = 1;
        door_hold = 1'b1;
        for (int k = 2; k <= 60; k++) begin
            nxt();
            if (k == 21) door_hold = 1'b0;
            if (door_open) cnt++;
        end
        chk("hold_len", cnt, 28);
`endif
        for (int i = 0; i < 3000; i++) begin
            call_req = ($urandom_range(0, 7) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
            floor_tick = ($urandom_range(0, 2) == 0);
`ifdef ELEV_DOOR_HOLD_EN
            door_hold = ($urandom_range(0, 9) == 0);
`endif
            rst_n = ($urandom_range(0, 499) != 0);
            nxt();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
